// File: rtl/mux_pkg.sv
// ============================================================================
// Module  : mux_pkg
// Brief   : Shared constants, types and select-order helpers for the 8:1
//           bit-select mux driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1
  } seq_state_t;

  function automatic sel_t first_sel(input logic msb_first);
    return msb_first ? sel_t'(N_IN - 1) : sel_t'(0);
  endfunction

  function automatic sel_t final_sel(input logic msb_first);
    return msb_first ? sel_t'(0) : sel_t'(N_IN - 1);
  endfunction

  function automatic sel_t next_sel(input sel_t sel, input logic msb_first);
    return msb_first ? (sel - sel_t'(1)) : (sel + sel_t'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_timer.sv
// ============================================================================
// Module  : step_timer
// Brief   : Per-bit hold counter; ticks on the last cycle of each select hold.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module step_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_TERM = CNT_W'(BIT_CYCLES - 1);

  generate
    if (BIT_CYCLES < 1) begin : g_bad_bit_cycles
      $error("step_timer: BIT_CYCLES must be >= 1");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = run && (cnt_q == C_TERM);

  // Counter rests at zero whenever not running, so each hold starts fresh.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || !run || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_81_sel_seq.sv
// ============================================================================
// Module  : mux_81_sel_seq
// Brief   : Captures a word and steps the 8:1 mux select through every bit,
//           emitting sample strobe, last-bit flag and end-of-word pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_81_sel_seq
  import mux_pkg::*;
#(
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] data_in,
  input  logic            abort,
  output logic [N_IN-1:0] i_out,
  output logic [SEL_W-1:0] s_out,
  output logic            bit_strobe,
  output logic            last,
  output logic            busy,
  output logic            done
);

  seq_state_t      state_q, state_d;
  logic [N_IN-1:0] i_out_q, i_out_d;
  sel_t            s_out_q, s_out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            w_in_scan;
  logic            w_capture;
  logic            w_tick;
  logic            w_last_bit;

  assign w_in_scan  = (state_q == SCAN);
  assign w_capture  = (state_q == IDLE) && in_valid;
  assign w_last_bit = (s_out_q == final_sel(MSB_FIRST));

  // Abort gates the timer, which both suppresses the strobe and clears the count.
  step_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_step_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (w_in_scan && !abort),
    .clr  (w_capture),
    .tick (w_tick)
  );

  always_comb begin
    state_d = state_q;
    i_out_d = i_out_q;
    s_out_d = s_out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SCAN;
          i_out_d = data_in;
          s_out_d = first_sel(MSB_FIRST);
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (w_tick) begin
          if (w_last_bit) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_out_d = next_sel(s_out_q, MSB_FIRST);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_out_q <= '0;
      s_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_out_q <= i_out_d;
      s_out_q <= s_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign bit_strobe = w_tick;
  assign last       = w_tick && w_last_bit;
  assign i_out      = i_out_q;
  assign s_out      = s_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_81_sel_seq.sv
// ============================================================================
// Module  : tb_mux_81_sel_seq
// Brief   : Directed bench for the mux select sequencer in three configurations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_81_sel_seq;

  logic clk;
  logic rst_n;

  logic       v1, a1, v2, a2, v3, a3;
  logic [7:0] d1, d2, d3;
  logic       rdy1, bs1, ls1, by1, dn1;
  logic       rdy2, bs2, ls2, by2, dn2;
  logic       rdy3, bs3, ls3, by3, dn3;
  logic [7:0] io1, io2, io3;
  logic [2:0] so1, so2, so3;
  logic       y1, y2, y3;

  int checks;
  int errors;

  mux_81_sel_seq #(.BIT_CYCLES(1), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .data_in(d1),
    .abort(a1), .i_out(io1), .s_out(so1), .bit_strobe(bs1), .last(ls1),
    .busy(by1), .done(dn1)
  );

  mux_81_sel_seq #(.BIT_CYCLES(1), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .data_in(d2),
    .abort(a2), .i_out(io2), .s_out(so2), .bit_strobe(bs2), .last(ls2),
    .busy(by2), .done(dn2)
  );

  mux_81_sel_seq #(.BIT_CYCLES(3), .MSB_FIRST(1'b0)) dut_slow (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .data_in(d3),
    .abort(a3), .i_out(io3), .s_out(so3), .bit_strobe(bs3), .last(ls3),
    .busy(by3), .done(dn3)
  );

  // Downstream 8:1 mux fed by each sequencer.
  assign y1 = io1[so1];
  assign y2 = io2[so2];
  assign y3 = io3[so3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: {s_out, bit_strobe, last, in_ready, busy, done, y}
  function automatic logic [8:0] obs1();
    return {so1, bs1, ls1, rdy1, by1, dn1, y1};
  endfunction
  function automatic logic [8:0] obs2();
    return {so2, bs2, ls2, rdy2, by2, dn2, y2};
  endfunction
  function automatic logic [8:0] obs3();
    return {so3, bs3, ls3, rdy3, by3, dn3, y3};
  endfunction

  task automatic test_reset();
    logic [7:0] exp_rst;
    exp_rst = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rst_n = 1'b0;
    #2;
    checks++;
    if ({so1, bs1, ls1, rdy1, by1, dn1} !== exp_rst || io1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_lsb: got %h/%h want %h/00", {so1, bs1, ls1, rdy1, by1, dn1}, io1, exp_rst);
    end
    checks++;
    if ({so2, bs2, ls2, rdy2, by2, dn2} !== exp_rst || io2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_msb: got %h/%h want %h/00", {so2, bs2, ls2, rdy2, by2, dn2}, io2, exp_rst);
    end
    checks++;
    if ({so3, bs3, ls3, rdy3, by3, dn3} !== exp_rst || io3 !== 8'h00) begin
      errors++;
      $display("FAIL reset_slow: got %h/%h want %h/00", {so3, bs3, ls3, rdy3, by3, dn3}, io3, exp_rst);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lsb_scan();
    logic       exp_y [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0] exp;
    @(posedge clk); #1;
    v1 = 1'b1; d1 = 8'hA5;
    @(negedge clk);
    checks++;
    if (rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL lsb_ready_idle: got %b want 1", rdy1);
    end
    @(posedge clk); #1;
    v1 = 1'b0; d1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = {3'(i), 1'b1, (i == 7), 1'b0, 1'b1, 1'b0, exp_y[i]};
      checks++;
      if (obs1() !== exp) begin
        errors++;
        $display("FAIL lsb_scan bit %0d: got %h want %h", i, obs1(), exp);
      end
    end
    @(negedge clk);
    exp = {3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    checks++;
    if (obs1() !== exp) begin
      errors++;
      $display("FAIL lsb_done: got %h want %h", obs1(), exp);
    end
    @(negedge clk);
    checks++;
    if (dn1 !== 1'b0) begin
      errors++;
      $display("FAIL lsb_done_single: got %b want 0", dn1);
    end
  endtask

  task automatic test_msb_scan();
    logic       exp_y [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [8:0] exp;
    @(posedge clk); #1;
    v2 = 1'b1; d2 = 8'h3C;
    @(posedge clk); #1;
    v2 = 1'b0; d2 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = {3'(7 - i), 1'b1, (i == 7), 1'b0, 1'b1, 1'b0, exp_y[i]};
      checks++;
      if (obs2() !== exp) begin
        errors++;
        $display("FAIL msb_scan bit %0d: got %h want %h", i, obs2(), exp);
      end
    end
    @(negedge clk);
    exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs2() !== exp) begin
      errors++;
      $display("FAIL msb_done: got %h want %h", obs2(), exp);
    end
  endtask

  task automatic test_slow_hold();
    logic [8:0] exp;
    @(posedge clk); #1;
    v3 = 1'b1; d3 = 8'hFF;
    @(posedge clk); #1;
    v3 = 1'b0; d3 = 8'h00;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      exp = {3'(c / 3), ((c % 3) == 2), (c == 23), 1'b0, 1'b1, 1'b0, 1'b1};
      checks++;
      if (obs3() !== exp) begin
        errors++;
        $display("FAIL slow_hold cycle %0d: got %h want %h", c, obs3(), exp);
      end
    end
    @(negedge clk);
    exp = {3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    checks++;
    if (obs3() !== exp) begin
      errors++;
      $display("FAIL slow_done: got %h want %h", obs3(), exp);
    end
  endtask

  task automatic test_abort();
    logic [8:0] exp;
    @(posedge clk); #1;
    v1 = 1'b1; d1 = 8'h5A;
    @(posedge clk); #1;
    v1 = 1'b0; d1 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({so1, bs1} !== {3'(i), 1'b1}) begin
        errors++;
        $display("FAIL abort_pre bit %0d: got %h want %h", i, {so1, bs1}, {3'(i), 1'b1});
      end
    end
    @(posedge clk); #1;
    a1 = 1'b1;
    @(negedge clk);
    exp = {3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs1() !== exp) begin
      errors++;
      $display("FAIL abort_cycle: got %h want %h", obs1(), exp);
    end
    @(posedge clk); #1;
    a1 = 1'b0;
    @(negedge clk);
    exp = {3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs1() !== exp || io1 !== 8'h5A) begin
      errors++;
      $display("FAIL abort_idle: got %h/%h want %h/5a", obs1(), io1, exp);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dn1 !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done %0d: got %b want 0", i, dn1);
      end
    end
    @(posedge clk); #1;
    v1 = 1'b1; d1 = 8'h01;
    @(posedge clk); #1;
    v1 = 1'b0; d1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = {3'(i), 1'b1, (i == 7), 1'b0, 1'b1, 1'b0, (i == 0)};
      checks++;
      if (obs1() !== exp) begin
        errors++;
        $display("FAIL abort_next bit %0d: got %h want %h", i, obs1(), exp);
      end
    end
    @(negedge clk);
    checks++;
    if (dn1 !== 1'b1) begin
      errors++;
      $display("FAIL abort_next_done: got %b want 1", dn1);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    v1 = 1'b1; d1 = 8'hA5;
    @(posedge clk); #1;
    d1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({io1, rdy1, by1} !== {8'hA5, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL b2b_hold bit %0d: got %h want %h", i, {io1, rdy1, by1}, {8'hA5, 1'b0, 1'b1});
      end
    end
    @(negedge clk);
    checks++;
    if ({io1, rdy1, dn1} !== {8'hA5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_done: got %h want %h", {io1, rdy1, dn1}, {8'hA5, 1'b1, 1'b1});
    end
    @(posedge clk); #1;
    v1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({io1, so1, by1, dn1} !== {8'h00, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_capture: got %h want %h", {io1, so1, by1, dn1}, {8'h00, 3'd0, 1'b1, 1'b0});
    end
    repeat (8) @(negedge clk);
    checks++;
    if ({dn1, by1} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_second_done: got %b want 10", {dn1, by1});
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] exp;
    @(posedge clk); #1;
    v1 = 1'b1; d1 = 8'hC3;
    @(posedge clk); #1;
    v1 = 1'b0; d1 = 8'h00;
    repeat (6) @(negedge clk);
    checks++;
    if (so1 !== 3'd5) begin
      errors++;
      $display("FAIL rst_pre_sel: got %0d want 5", so1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({so1, bs1, ls1, rdy1, by1, dn1, io1} !== {3'd0, 5'b00100, 8'h00}) begin
      errors++;
      $display("FAIL rst_async: got %h want %h", {so1, bs1, ls1, rdy1, by1, dn1, io1}, {3'd0, 5'b00100, 8'h00});
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rdy1, by1, dn1} !== 3'b100) begin
        errors++;
        $display("FAIL rst_after %0d: got %b want 100", i, {rdy1, by1, dn1});
      end
    end
    @(posedge clk); #1;
    v1 = 1'b1; d1 = 8'h80;
    @(posedge clk); #1;
    v1 = 1'b0; d1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = {3'(i), 1'b1, (i == 7), 1'b0, 1'b1, 1'b0, (i == 7)};
      checks++;
      if (obs1() !== exp) begin
        errors++;
        $display("FAIL rst_next bit %0d: got %h want %h", i, obs1(), exp);
      end
    end
    @(negedge clk);
    checks++;
    if (dn1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_next_done: got %b want 1", dn1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    v1 = 1'b0; a1 = 1'b0; d1 = 8'h00;
    v2 = 1'b0; a2 = 1'b0; d2 = 8'h00;
    v3 = 1'b0; a3 = 1'b0; d3 = 8'h00;
    rst_n = 1'b1;
    test_reset();
    test_lsb_scan();
    test_msb_scan();
    test_slow_hold();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
